// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: saturating counts and EQ-run lock detection on comparator results
module cmp_result_tracker #(
    parameter int CNT_W      = 8,
    parameter int LOCK_LEN   = 4,
    parameter int UNLOCK_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             r_valid,
    input  logic [2:0]       R,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             locked,
    output logic             lock_pulse,
    output logic             unlock_pulse,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, eq_cnt_q, eq_cnt_d, lt_cnt_q, lt_cnt_d;
    logic [3:0]       eq_run_q, eq_run_d, ne_run_q, ne_run_d;
    logic             lock_pulse_q, lock_pulse_d, unlock_pulse_q, unlock_pulse_d;
    logic             err_q, err_d;
    logic             is_gt, is_eq, is_lt;

    assign is_gt = R == 3'b100;
    assign is_eq = R == 3'b010;
    assign is_lt = R == 3'b001;

    always_comb begin
        state_d        = state_q;
        gt_cnt_d       = gt_cnt_q;
        eq_cnt_d       = eq_cnt_q;
        lt_cnt_d       = lt_cnt_q;
        eq_run_d       = eq_run_q;
        ne_run_d       = ne_run_q;
        err_d          = err_q;
        lock_pulse_d   = 1'b0;
        unlock_pulse_d = 1'b0;
        if (clr) begin
            state_d  = en ? SEARCH : IDLE;
            gt_cnt_d = '0;
            eq_cnt_d = '0;
            lt_cnt_d = '0;
            eq_run_d = '0;
            ne_run_d = '0;
            err_d    = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = en ? SEARCH : IDLE;
        end else if (!en) begin
            state_d  = IDLE;
            eq_run_d = '0;
            ne_run_d = '0;
        end else if (r_valid) begin
            if (is_gt && gt_cnt_q != '1) gt_cnt_d = gt_cnt_q + CNT_W'(1);
            if (is_eq && eq_cnt_q != '1) eq_cnt_d = eq_cnt_q + CNT_W'(1);
            if (is_lt && lt_cnt_q != '1) lt_cnt_d = lt_cnt_q + CNT_W'(1);
            if (!(is_gt || is_eq || is_lt)) err_d = 1'b1;
            if (is_eq) begin
                // eq_run keeps counting while LOCKED but must not wrap back to a lock value
                eq_run_d = (eq_run_q == 4'hf) ? eq_run_q : eq_run_q + 4'd1;
                ne_run_d = '0;
                if (state_q == SEARCH && eq_run_q + 4'd1 == 4'(LOCK_LEN)) begin
                    state_d      = LOCKED;
                    eq_run_d     = '0;
                    lock_pulse_d = 1'b1;
                end
            end else begin
                eq_run_d = '0;
                if (state_q == LOCKED) begin
                    ne_run_d = ne_run_q + 4'd1;
                    if (ne_run_q + 4'd1 == 4'(UNLOCK_LEN)) begin
                        state_d        = SEARCH;
                        ne_run_d       = '0;
                        unlock_pulse_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gt_cnt_q       <= '0;
            eq_cnt_q       <= '0;
            lt_cnt_q       <= '0;
            eq_run_q       <= '0;
            ne_run_q       <= '0;
            err_q          <= 1'b0;
            lock_pulse_q   <= 1'b0;
            unlock_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gt_cnt_q       <= gt_cnt_d;
            eq_cnt_q       <= eq_cnt_d;
            lt_cnt_q       <= lt_cnt_d;
            eq_run_q       <= eq_run_d;
            ne_run_q       <= ne_run_d;
            err_q          <= err_d;
            lock_pulse_q   <= lock_pulse_d;
            unlock_pulse_q <= unlock_pulse_d;
        end
    end

    assign gt_cnt       = gt_cnt_q;
    assign eq_cnt       = eq_cnt_q;
    assign lt_cnt       = lt_cnt_q;
    assign locked       = state_q == LOCKED;
    assign lock_pulse   = lock_pulse_q;
    assign unlock_pulse = unlock_pulse_q;
    assign err          = err_q;
endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb_cmp_result_tracker: directed self-checking bench for cmp_result_tracker
module tb_cmp_result_tracker;
    logic       clk = 1'b0;
    logic       rst_n, en, clr, r_valid;
    logic [2:0] R;
    logic [7:0] gt_cnt, eq_cnt, lt_cnt;
    logic       locked, lock_pulse, unlock_pulse, err;
    int         checks = 0, errors = 0;

    cmp_result_tracker dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .r_valid(r_valid), .R(R),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .locked(locked),
        .lock_pulse(lock_pulse), .unlock_pulse(unlock_pulse), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] r);
        r_valid = v;
        R       = r;
        @(posedge clk);
        #1;
        r_valid = 1'b0;
    endtask

    task automatic cnts(input string tag, input int g, input int e, input int l);
        check({tag, " gt"}, 32'(gt_cnt), g);
        check({tag, " eq"}, 32'(eq_cnt), e);
        check({tag, " lt"}, 32'(lt_cnt), l);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; r_valid = 1'b0; R = 3'b000;
        step(0, 0); step(0, 0);
        cnts("reset", 0, 0, 0);
        check("reset locked", locked, 0);
        check("reset lock_pulse", lock_pulse, 0);
        check("reset unlock_pulse", unlock_pulse, 0);
        check("reset err", err, 0);
        rst_n = 1'b1; en = 1'b1;
        step(1, 3'b010);
        check("idle sample ignored", eq_cnt, 0);
        // basic lock
        repeat (3) step(1, 3'b010);
        check("no lock after 3", locked, 0);
        step(1, 3'b010);
        check("lock after 4", locked, 1);
        check("lock_pulse", lock_pulse, 1);
        cnts("lock", 0, 4, 0);
        step(0, 0);
        check("lock_pulse one cycle", lock_pulse, 0);
        check("still locked", locked, 1);
        // unlock on two mismatches
        step(1, 3'b100);
        check("locked after 1 ne", locked, 1);
        step(1, 3'b001);
        check("unlock", locked, 0);
        check("unlock_pulse", unlock_pulse, 1);
        cnts("unlock", 1, 4, 1);
        step(0, 0);
        check("unlock_pulse one cycle", unlock_pulse, 0);
        // broken non-EQ run keeps lock
        repeat (4) step(1, 3'b010);
        check("relock", locked, 1);
        step(1, 3'b100); step(1, 3'b010); step(1, 3'b100);
        check("ne run broken stays locked", locked, 1);
        cnts("broken", 3, 9, 1);
        step(1, 3'b100);
        check("unlock after 2 ne", locked, 0);
        // r_valid gaps transparent
        for (int i = 0; i < 3; i++) begin
            step(1, 3'b010);
            repeat (3) step(0, 0);
        end
        check("gap no lock yet", locked, 0);
        step(1, 3'b010);
        check("gap lock on 4th", locked, 1);
        check("gap eq", eq_cnt, 13);
        step(1, 3'b100); step(1, 3'b100);
        check("gap unlock", locked, 0);
        // interrupted run leaves eq_run=1
        step(1, 3'b010); step(1, 3'b010); step(1, 3'b010); step(1, 3'b100); step(1, 3'b010);
        check("interrupted no lock", locked, 0);
        step(1, 3'b010); step(1, 3'b010);
        check("eq_run 3 no lock", locked, 0);
        step(1, 3'b010);
        check("eq_run 4 lock", locked, 1);
        cnts("interrupted", 7, 20, 1);
        step(1, 3'b001); step(1, 3'b001);
        check("interrupted unlock", locked, 0);
        // malformed code
        repeat (3) step(1, 3'b010);
        step(1, 3'b011);
        check("err set", err, 1);
        cnts("malformed", 7, 23, 3);
        repeat (3) step(1, 3'b010);
        check("malformed broke run", locked, 0);
        step(1, 3'b010);
        check("lock after malformed", locked, 1);
        check("err sticky", err, 1);
        step(1, 3'b111); step(1, 3'b000);
        check("malformed unlock", locked, 0);
        cnts("malformed unlock", 7, 27, 3);
        // clear with same-cycle sample
        clr = 1'b1;
        step(1, 3'b010);
        clr = 1'b0;
        cnts("clr", 0, 0, 0);
        check("clr err", err, 0);
        repeat (4) step(1, 3'b010);
        check("lock after clr", locked, 1);
        clr = 1'b1;
        step(1, 3'b010);
        clr = 1'b0;
        check("clr while locked eq", eq_cnt, 0);
        check("clr while locked unlock", locked, 0);
        check("clr no unlock_pulse", unlock_pulse, 0);
        // saturation
        repeat (255) step(1, 3'b100);
        check("gt at max", gt_cnt, 255);
        repeat (5) step(1, 3'b100);
        check("gt saturated", gt_cnt, 255);
        step(1, 3'b001);
        cnts("after sat", 255, 0, 1);
        // en=0 while locked
        repeat (4) step(1, 3'b010);
        check("lock before en drop", locked, 1);
        en = 1'b0;
        step(1, 3'b100);
        check("en drop locked", locked, 0);
        check("en drop no unlock_pulse", unlock_pulse, 0);
        cnts("en drop", 255, 4, 1);
        step(1, 3'b010);
        check("idle holds eq", eq_cnt, 4);
        en = 1'b1;
        step(1, 3'b010);
        check("en rise ignored", eq_cnt, 4);
        repeat (3) step(1, 3'b010);
        check("runs cleared by en drop", locked, 0);
        step(1, 3'b010);
        check("lock after en return", locked, 1);
        // reset mid-run
        rst_n = 1'b0;
        step(1, 3'b010);
        cnts("mid reset", 0, 0, 0);
        check("mid reset locked", locked, 0);
        check("mid reset pulse", lock_pulse, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
